prog_loader: RTL
================

# prog_loader

Byte-stream program loader that fills the instruction memory of the single-cycle CPU and holds the CPU in reset until a complete, checksum-verified image is written. It sits between an external byte source and the instruction-memory write port. It is the writer side of the program memory that the CPU only ever reads. It owns the CPU's run enable.

## Interface

Parameters:
- ADDR_W, 10: instruction-memory address width.
- MAX_WORDS, 1024: largest accepted image, in words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; one clock, no other clock domains.
- in_valid  in  1  byte source has in_data valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs on a cycle with in_valid && in_ready.
- restart  in  1  restart request, honoured only in DONE or ERR.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  instruction word.
- cpu_run  out  1  high = CPU released from reset.
- done  out  1  image loaded and verified.
- err  out  1  image rejected.

## Operation

- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words as HI byte then LO byte, then CSUM.
- CSUM is the XOR of all 2N word bytes. Length bytes are excluded. For N = 0, CSUM must be 0x00.
- FSM states: LEN_HI, LEN_LO, W_HI, W_LO, CSUM, DONE, ERR. Reset state is LEN_HI.
- LEN_HI → LEN_LO on transfer; the high byte is latched.
- LEN_LO on transfer:
  - N > MAX_WORDS → ERR.
  - N = 0 → CSUM.
  - otherwise → W_HI; word counter and address cleared to 0.
- W_HI → W_LO on transfer; the byte is latched.
- W_LO on transfer:
  - Word {hi, lo} is written at the current address.
  - Address and count increment.
  - Last word → CSUM, else → W_HI.
- CSUM on transfer:
  - Byte equal to the running XOR → DONE.
  - Otherwise → ERR.
- DONE / ERR:
  - restart = 1 → LEN_HI; running XOR, count and address are cleared.
  - restart is ignored in all other states.
- Words already written before an ERR stay in memory; cpu_run never rises for a rejected image.
- Address does not wrap: N ≤ MAX_WORDS guarantees the last address is N−1.

## Timing

- Reset values of all registered outputs: in_ready 1 (state LEN_HI), mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, done 0, err 0.
- in_ready is combinational from state only: 1 in LEN_HI..CSUM, 0 in DONE and ERR. It never depends on in_valid.
- One byte per cycle at most; back-to-back transfers run at full rate.
- Write latency: mem_we, mem_addr and mem_wdata are registered. They are asserted for exactly one cycle, the cycle after the W_LO transfer.
- mem_addr and mem_wdata hold their last values when mem_we = 0.
- done or err goes high the cycle after the CSUM transfer, and cpu_run rises in the same cycle as done.
- The CSUM transfer comes at least one cycle after the last W_LO transfer, so the last write always completes before cpu_run rises.
- restart accepted in DONE/ERR: the next cycle has state LEN_HI and cpu_run, done, err all 0.
- Asynchronous reset mid-load:
  - All outputs go to reset values immediately; mem_we drops without completing a write.
  - On deassertion the loader waits in LEN_HI for a fresh stream header.
- in_valid while in_ready = 0 is ignored; the byte is not consumed.

## Structure

- Shared package prog_loader_pkg holds:
  - state encodings (3-bit);
  - the byte width (8) and the instruction width (16, matching the CPU instruction memory).
- Single module; no sub-module is natural. The FSM, the 16-bit length register, the word counter/address, the byte latch and the XOR accumulator are all small.
- The top level drives the CPU reset from !cpu_run, and connects the mem_* outputs to the instruction-memory write port.

## Test plan

- N = 2, words 0x1234, 0xABCD, CSUM 0x12^0x34^0xAB^0xCD = 0x40:
  - writes addr 0 = 0x1234 and addr 1 = 0xABCD, each with a one-cycle mem_we;
  - done = 1 and cpu_run = 1 one cycle after CSUM.
- Same image with CSUM 0x41: both writes occur; err = 1, cpu_run stays 0, in_ready = 0.
- Header 0x04 0x01 (N = 1025 > 1024): err = 1 the cycle after LEN_LO, and no mem_we ever pulses.
- N = 0 with CSUM 0x00: done = 1 with no writes. N = 0 with CSUM 0x01: err = 1.
- Load with in_valid toggling every other cycle, and restart pulsed mid-load:
  - data is unchanged and restart is ignored;
  - after done, restart gives cpu_run = 0 next cycle, then a second image reloads correctly.
- Assert reset during W_LO of word 3 of 8:
  - outputs return to reset values asynchronously;
  - a subsequent full image starts at address 0 and completes with done = 1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths and state encoding for the program loader
package prog_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 16;
    localparam int LEN_W   = 16;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_W_HI   = 3'd2,
        ST_W_LO   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Terminal states stop consuming bytes until a restart.
    function automatic logic accepts_bytes(input state_t s);
        return (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that writes instruction memory and gates CPU run
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               restart,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_run,
    output logic               done,
    output logic               err
);

    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

    state_t              state;
    logic [BYTE_W-1:0]   len_hi_q;
    logic [BYTE_W-1:0]   byte_hi_q;
    logic [BYTE_W-1:0]   xor_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                xfer;
    logic [LEN_W-1:0]    n_in;
    logic                last_word;

    assign in_ready  = accepts_bytes(state);
    assign xfer      = in_valid && in_ready;
    assign n_in      = {len_hi_q, in_data};
    assign last_word = ((cnt_q + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LEN_HI;
            len_hi_q  <= '0;
            byte_hi_q <= '0;
            xor_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi_q <= in_data;
                        state    <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_q  <= n_in;
                        cnt_q  <= '0;
                        addr_q <= '0;
                        xor_q  <= '0;
                        if (n_in > MAX_N) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else if (n_in == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_W_HI;
                        end
                    end
                end
                ST_W_HI: begin
                    if (xfer) begin
                        byte_hi_q <= in_data;
                        xor_q     <= xor_q ^ in_data;
                        state     <= ST_W_LO;
                    end
                end
                ST_W_LO: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= {byte_hi_q, in_data};
                        xor_q     <= xor_q ^ in_data;
                        addr_q    <= addr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q + LEN_W'(1);
                        state     <= last_word ? ST_CSUM : ST_W_HI;
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (in_data == xor_q) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state   <= ST_LEN_HI;
                        xor_q   <= '0;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        cpu_run <= 1'b0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                default: state <= ST_LEN_HI;
            endcase
        end
    end

endmodule
